// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the N-channel stream multiplexer.
//   state_t  : packet-lock state (idle / locked to one channel)
//   MODE_SEL : channel chosen by the external sel port
//   MODE_RR  : channel chosen by the internal round-robin arbiter
package stream_mux_pkg;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  localparam int unsigned MODE_SEL = 0;
  localparam int unsigned MODE_RR  = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : per-channel request
//   ptr    : last served channel; the search starts at (ptr+1) mod NUM_CH and wraps
//   gnt    : index of the first requesting channel found
//   gnt_ok : at least one request present
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt,
  output logic              gnt_ok
);

  int unsigned     idx;
  logic [SEL_W-1:0] idx_s;

  always_comb begin
    gnt    = '0;
    gnt_ok = 1'b0;
    idx    = 0;
    idx_s  = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx   = (32'(ptr) + i) % NUM_CH;
      idx_s = SEL_W'(idx);
      if (!gnt_ok && req[idx_s]) begin
        gnt    = idx_s;
        gnt_ok = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// The grant is locked from the first beat of a packet until its last beat, so
// packets never interleave.
//   clk, rst_n     : clock, synchronous active-low reset
//   sel            : channel select (MODE_SEL only)
//   in_valid/in_data/in_last/in_ready : per-channel input streams
//   out_valid/out_data/out_last/out_ch/out_ready : registered output stream
module stream_mux_n
  import stream_mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MODE   = 0,
  localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_last,
  output logic [NUM_CH-1:0]        in_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [SEL_W-1:0]         out_ch,
  input  logic                     out_ready
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [SEL_W-1:0]  rr_gnt;
  logic              rr_ok;
  logic [SEL_W-1:0]  grant;
  logic              grant_ok;
  logic              g_valid;
  logic [DATA_W-1:0] g_data;
  logic              g_last;
  logic              load_en;
  logic              accept;

  if (MODE == MODE_RR) begin : g_rr
    rr_arbiter #(
      .NUM_CH (NUM_CH),
      .SEL_W  (SEL_W)
    ) u_arb (
      .req    (in_valid),
      .ptr    (rr_ptr_q),
      .gnt    (rr_gnt),
      .gnt_ok (rr_ok)
    );
  end else begin : g_sel
    // Arbiter absent in select mode; the pointer is kept referenced but never granted.
    assign rr_gnt = rr_ptr_q;
    assign rr_ok  = 1'b0;
  end

  assign load_en = !out_valid || out_ready;

  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    if (state_q == ST_LOCKED) begin
      grant    = lock_ch_q;
      grant_ok = 1'b1;
    end else if (MODE == MODE_SEL) begin
      grant    = sel;
      grant_ok = (32'(sel) < NUM_CH);
    end else begin
      grant    = rr_gnt;
      grant_ok = rr_ok;
    end
  end

  // Gather the granted channel's beat; loop form avoids indexing past NUM_CH
  // when sel is out of range.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    g_last  = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (grant_ok && (SEL_W'(c) == grant)) begin
        g_valid = in_valid[c];
        g_data  = in_data[c*DATA_W +: DATA_W];
        g_last  = in_last[c];
      end
    end
  end

  assign in_ready = (grant_ok && load_en && rst_n) ? (NUM_CH'(1) << grant) : '0;
  assign accept   = g_valid && grant_ok && load_en && rst_n;

  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      if (g_last) begin
        state_d = ST_IDLE;
        if (MODE == MODE_RR) begin
          rr_ptr_d = grant;
        end
      end else if (state_q == ST_IDLE) begin
        state_d   = ST_LOCKED;
        lock_ch_d = grant;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lock_ch_q <= '0;
      rr_ptr_q  <= SEL_W'(NUM_CH - 1);
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      if (load_en) begin
        out_valid <= accept;
      end
      if (accept) begin
        out_data <= g_data;
        out_last <= g_last;
        out_ch   <= grant;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_n.sv
module tb_stream_mux_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // DUT 0: select mode, 4 channels
  logic        rst0;
  logic [1:0]  sel0;
  logic [3:0]  v0, l0, r0;
  logic [31:0] d0;
  logic        ov0, ol0, ordy0;
  logic [7:0]  od0;
  logic [1:0]  oc0;

  stream_mux_n #(.NUM_CH(4), .DATA_W(8), .MODE(0)) u0 (
    .clk(clk), .rst_n(rst0), .sel(sel0), .in_valid(v0), .in_data(d0), .in_last(l0),
    .in_ready(r0), .out_valid(ov0), .out_data(od0), .out_last(ol0), .out_ch(oc0),
    .out_ready(ordy0)
  );

  // DUT 1: round-robin mode, 4 channels
  logic        rst1;
  logic [1:0]  sel1;
  logic [3:0]  v1, l1, r1;
  logic [31:0] d1;
  logic        ov1, ol1, ordy1;
  logic [7:0]  od1;
  logic [1:0]  oc1;

  stream_mux_n #(.NUM_CH(4), .DATA_W(8), .MODE(1)) u1 (
    .clk(clk), .rst_n(rst1), .sel(sel1), .in_valid(v1), .in_data(d1), .in_last(l1),
    .in_ready(r1), .out_valid(ov1), .out_data(od1), .out_last(ol1), .out_ch(oc1),
    .out_ready(ordy1)
  );

  // DUT 2: select mode, 3 channels (sel=3 is out of range)
  logic        rst2;
  logic [1:0]  sel2;
  logic [2:0]  v2, l2, r2;
  logic [23:0] d2;
  logic        ov2, ol2, ordy2;
  logic [7:0]  od2;
  logic [1:0]  oc2;

  stream_mux_n #(.NUM_CH(3), .DATA_W(8), .MODE(0)) u2 (
    .clk(clk), .rst_n(rst2), .sel(sel2), .in_valid(v2), .in_data(d2), .in_last(l2),
    .in_ready(r2), .out_valid(ov2), .out_data(od2), .out_last(ol2), .out_ch(oc2),
    .out_ready(ordy2)
  );

  // One row = inputs applied after a falling edge, in_ready expected before the
  // rising edge, and output register contents expected after it.
  // Channel 1 always carries d1 with last=1; channel 2 carries d2 with l2.
  typedef struct {
    logic [1:0] sel;
    logic [3:0] valid;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       l2;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [7:0] exp_od;
    logic       exp_ol;
    logic [1:0] exp_oc;
  } vec_t;

  vec_t tbl[6];

  task automatic step0(input vec_t v);
    sel0  = v.sel;
    v0    = v.valid;
    d0    = {8'h00, v.d2, v.d1, 8'h00};
    l0    = {1'b0, v.l2, 1'b1, 1'b0};
    ordy0 = 1'b1;
    #1 chk("tbl_in_ready", 32'(r0), 32'(v.exp_rdy));
    @(negedge clk);
    chk("tbl_out_valid", 32'(ov0), 32'(v.exp_ov));
    chk("tbl_out_data", 32'(od0), 32'(v.exp_od));
    chk("tbl_out_last", 32'(ol0), 32'(v.exp_ol));
    chk("tbl_out_ch", 32'(oc0), 32'(v.exp_oc));
  endtask

  initial begin
    //          sel    valid    d1     d2     l2    rdy      ov    od     ol    oc
    tbl[0] = '{2'd2, 4'b0110, 8'hB1, 8'hA1, 1'b0, 4'b0100, 1'b1, 8'hA1, 1'b0, 2'd2};
    tbl[1] = '{2'd1, 4'b0110, 8'hB1, 8'hA2, 1'b0, 4'b0100, 1'b1, 8'hA2, 1'b0, 2'd2};
    tbl[2] = '{2'd1, 4'b0010, 8'hB1, 8'h00, 1'b0, 4'b0100, 1'b0, 8'hA2, 1'b0, 2'd2};
    tbl[3] = '{2'd1, 4'b0110, 8'hB1, 8'hA3, 1'b1, 4'b0100, 1'b1, 8'hA3, 1'b1, 2'd2};
    tbl[4] = '{2'd1, 4'b0010, 8'hB1, 8'h00, 1'b0, 4'b0010, 1'b1, 8'hB1, 1'b1, 2'd1};
    tbl[5] = '{2'd1, 4'b0000, 8'hB1, 8'h00, 1'b0, 4'b0010, 1'b0, 8'hB1, 1'b1, 2'd1};

    rst0 = 1'b0; sel0 = '0; v0 = 4'hF; d0 = 32'h44332211; l0 = '0; ordy0 = 1'b1;
    rst1 = 1'b0; sel1 = '0; v1 = '0;   d1 = '0;           l1 = '0; ordy1 = 1'b1;
    rst2 = 1'b0; sel2 = '0; v2 = '0;   d2 = '0;           l2 = '0; ordy2 = 1'b1;

    // Reset held for 3 clocks with all channels valid
    repeat (3) begin
      #1 chk("rst_in_ready", 32'(r0), 32'h0);
      @(negedge clk);
      chk("rst_out_valid", 32'(ov0), 32'h0);
      chk("rst_out_data", 32'(od0), 32'h0);
    end
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;

    // Select lock, locked channel stalling, then release to channel 1
    for (int i = 0; i < 6; i++) step0(tbl[i]);

    // Backpressure
    sel0 = 2'd0; v0 = 4'b0001; d0 = 32'h00000055; l0 = 4'b0001; ordy0 = 1'b1;
    @(negedge clk);
    chk("bp_load_valid", 32'(ov0), 32'h1);
    chk("bp_load_data", 32'(od0), 32'h55);
    ordy0 = 1'b0; d0 = 32'h00000066;
    repeat (4) begin
      #1 chk("bp_in_ready", 32'(r0), 32'h0);
      @(negedge clk);
      chk("bp_hold_valid", 32'(ov0), 32'h1);
      chk("bp_hold_data", 32'(od0), 32'h55);
    end
    ordy0 = 1'b1;
    #1 chk("bp_release_rdy", 32'(r0), 32'h1);
    @(negedge clk);
    chk("bp_next_valid", 32'(ov0), 32'h1);
    chk("bp_next_data", 32'(od0), 32'h66);
    v0 = '0;
    @(negedge clk);
    chk("bp_drain_valid", 32'(ov0), 32'h0);

    // Round-robin fairness: single-beat packets on all channels
    v1 = 4'hF; d1 = 32'h13121110; l1 = 4'hF; ordy1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_valid", 32'(ov1), 32'h1);
      chk("rr_data", 32'(od1), 32'h10 + 32'(k % 4));
      chk("rr_ch", 32'(oc1), 32'(k % 4));
    end
    v1 = '0;
    @(negedge clk);
    chk("rr_idle_valid", 32'(ov1), 32'h0);

    // Reset mid-packet: ch1 locked after two beats
    v1 = 4'b0010; d1 = 32'h00002100; l1 = 4'b0000;
    #1 chk("mid_rdy1", 32'(r1), 32'b0010);
    @(negedge clk);
    chk("mid_beat1", 32'(od1), 32'h21);
    chk("mid_ch1", 32'(oc1), 32'h1);
    v1 = 4'b0011; d1 = 32'h00002230; l1 = 4'b0001;
    #1 chk("mid_lock_rdy", 32'(r1), 32'b0010);
    @(negedge clk);
    chk("mid_beat2", 32'(od1), 32'h22);
    rst1 = 1'b0;
    #1 chk("mid_rst_rdy", 32'(r1), 32'h0);
    @(negedge clk);
    chk("mid_rst_valid", 32'(ov1), 32'h0);
    chk("mid_rst_data", 32'(od1), 32'h0);
    rst1 = 1'b1; d1 = 32'h00002330;
    #1 chk("mid_after_rdy", 32'(r1), 32'b0001);
    @(negedge clk);
    chk("mid_after_data", 32'(od1), 32'h30);
    chk("mid_after_ch", 32'(oc1), 32'h0);
    chk("mid_after_last", 32'(ol1), 32'h1);

    // Out-of-range select on the 3-channel instance
    sel2 = 2'd0; v2 = 3'b001; d2 = 24'h000077; l2 = 3'b001; ordy2 = 1'b1;
    @(negedge clk);
    chk("oor_load_valid", 32'(ov2), 32'h1);
    sel2 = 2'd3; v2 = 3'b111; ordy2 = 1'b0;
    #1 chk("oor_rdy_stall", 32'(r2), 32'h0);
    @(negedge clk);
    chk("oor_hold_data", 32'(od2), 32'h77);
    ordy2 = 1'b1;
    #1 chk("oor_rdy_free", 32'(r2), 32'h0);
    @(negedge clk);
    chk("oor_drain_valid", 32'(ov2), 32'h0);
    #1 chk("oor_rdy_idle", 32'(r2), 32'h0);
    @(negedge clk);
    chk("oor_idle_valid", 32'(ov2), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
